seg_stream_encoder: RTL and testbench



---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_stream_encoder_bin2bcd.sv | 62 ++++++
 rtl/seg_stream_encoder.sv | 217 +++++++++++++++++++++
 tb/tb_seg_stream_encoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the segment stream encoder.
//   state_t   - frame FSM states (IDLE / CONVERT / STREAM)
//   SEG_LUT   - 7-segment patterns for digits 0..F, bit i = segment a..g
//   SEG_BLANK - pattern for a blanked digit
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    STREAM
  } state_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_stream_encoder_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One shift-add-3 step per cycle; DATA_W steps after i_start.
//   clk, rst     - clock, synchronous active-high reset
//   i_start      - load i_data and begin conversion
//   i_data       - binary value
//   o_done       - high during the cycle whose edge performs the final step
//   o_bcd        - BCD result, 4*MAX_DIGITS bits, digit 0 in the low nibble
//   o_overflow   - a 1 was shifted out of the top of the BCD register
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    o_done,
  output logic [4*MAX_DIGITS-1:0] o_bcd,
  output logic                    o_overflow
);

  localparam int BW    = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_bin;
  logic [BW-1:0]     r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [BW-1:0]     w_adj;

  always_comb begin
    w_adj = '0;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? r_bcd[4*d +: 4] + 4'd3
                                                  : r_bcd[4*d +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_data;
      r_bcd <= '0;
      r_cnt <= CNT_W'(DATA_W);
      r_ovf <= 1'b0;
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj[BW-2:0], r_bin[DATA_W-1]};
      r_bin <= r_bin << 1;
      r_ovf <= r_ovf | w_adj[BW-1];
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done     = (r_cnt == CNT_W'(1));
  assign o_bcd      = r_bcd;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/seg_stream_encoder.sv
// seg_stream_encoder: captures a binary value, converts it to decimal
// (sequential double-dabble) or hex digits and streams each digit's segment
// pattern one bit per next_bit strobe, digit 0 first, segment a first.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant nonzero displayed digit; digit 0 is never blanked).
//   clk, rst     - clock, synchronous active-high reset
//   start        - frame request, accepted only in IDLE
//   data         - value to display
//   digit_count  - digits to emit (0 -> 1, >MAX_DIGITS -> MAX_DIGITS)
//   hex_mode     - 1 = hex, 0 = decimal
//   dp_mask      - per-digit decimal point
//   next_bit     - consumer strobe, advances the stream in STREAM
//   bit_data     - current segment bit
//   bit_valid    - bit_data meaningful
//   busy         - frame in progress
//   done         - one-cycle pulse at frame completion
//   overflow     - value did not fit in the displayed digits
module seg_stream_encoder
  import seg_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int MAX_DIGITS = 5,
  parameter int SEG_W      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_W-1:0]                 data,
  input  logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  input  logic                              hex_mode,
  input  logic [MAX_DIGITS-1:0]             dp_mask,
  input  logic                              next_bit,
  output logic                              bit_data,
  output logic                              bit_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = 4 * MAX_DIGITS;

  state_t r_state, w_next;

  logic [DATA_W-1:0]     r_data;
  logic [CW-1:0]         r_count;
  logic                  r_hex;
  logic [MAX_DIGITS-1:0] r_dp;
  logic [CW-1:0]         r_dig;
  logic [2:0]            r_bit;
  logic                  r_done;
  logic                  r_ovf_valid;

  logic                  w_accept;
  logic [CW-1:0]         w_count_eff;
  logic                  w_bcd_last;
  logic [BW-1:0]         w_bcd;
  logic                  w_bcd_ovf;
  logic [3:0]            w_hex_nib [MAX_DIGITS];
  logic [3:0]            w_nib     [MAX_DIGITS];
  logic [3:0]            w_sel_nib;
  logic                  w_sel_dp;
  logic [6:0]            w_seg7;
  logic [7:0]            w_seg;
  logic                  w_last_bit;
  logic [31:0]           w_hex_lim;
  logic                  w_hex_ovf;
  logic                  w_dec_ovf;

  assign w_accept = (r_state == IDLE) && start;

  always_comb begin
    if (digit_count == '0)
      w_count_eff = CW'(1);
    else if (digit_count > CW'(MAX_DIGITS))
      w_count_eff = CW'(MAX_DIGITS);
    else
      w_count_eff = digit_count;
  end

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_bcd (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept && !hex_mode),
    .i_data     (data),
    .o_done     (w_bcd_last),
    .o_bcd      (w_bcd),
    .o_overflow (w_bcd_ovf)
  );

  // Nibbles beyond the input width read as zero.
  for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_nib
    if (g < DATA_W / 4) begin : g_in
      assign w_hex_nib[g] = r_data[4*g +: 4];
    end else begin : g_pad
      assign w_hex_nib[g] = 4'h0;
    end
  end

  always_comb begin
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      w_nib[d] = r_hex ? w_hex_nib[d] : w_bcd[4*d +: 4];
    end
  end

  // Overflow is derived from frame registers that stay frozen until the next
  // accepted start; r_ovf_valid gates it so it reads 0 until STREAM entry.
  assign w_hex_lim = 32'(r_count) << 2;

  always_comb begin
    w_hex_ovf = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i >= w_hex_lim && r_data[i]) w_hex_ovf = 1'b1;
    end
  end

  always_comb begin
    w_dec_ovf = w_bcd_ovf;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      if (d >= 32'(r_count) && w_bcd[4*d +: 4] != 4'h0) w_dec_ovf = 1'b1;
    end
  end

  always_comb begin
    w_sel_nib = 4'h0;
    w_sel_dp  = 1'b0;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      if (CW'(d) == r_dig) begin
        w_sel_nib = w_nib[d];
        w_sel_dp  = r_dp[d];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [CW-1:0] w_msd;

  always_comb begin
    w_msd = '0;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      if (d < 32'(r_count) && w_nib[d] != 4'h0) w_msd = CW'(d);
    end
  end

  assign w_seg7 = (r_dig > w_msd) ? SEG_BLANK : SEG_LUT[w_sel_nib];
`else
  assign w_seg7 = SEG_LUT[w_sel_nib];
`endif

  assign w_seg      = {(SEG_W == 8) ? w_sel_dp : 1'b0, w_seg7};
  assign w_last_bit = (r_bit == 3'(SEG_W - 1)) && (r_dig == r_count - CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = hex_mode ? STREAM : CONVERT;
      CONVERT: if (w_bcd_last) w_next = STREAM;
      STREAM:  if (next_bit && w_last_bit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (r_state != IDLE);
    bit_valid = (r_state == STREAM);
    bit_data  = (r_state == STREAM) ? w_seg[r_bit] : 1'b0;
    done      = r_done;
    overflow  = r_ovf_valid && (r_hex ? w_hex_ovf : w_dec_ovf);
  end

  // Frame capture, bit/digit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_count     <= CW'(1);
      r_hex       <= 1'b0;
      r_dp        <= '0;
      r_dig       <= '0;
      r_bit       <= '0;
      r_done      <= 1'b0;
      r_ovf_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_data      <= data;
        r_count     <= w_count_eff;
        r_hex       <= hex_mode;
        r_dp        <= dp_mask;
        r_dig       <= '0;
        r_bit       <= '0;
        r_ovf_valid <= hex_mode;
      end else if (r_state == CONVERT && w_bcd_last) begin
        r_ovf_valid <= 1'b1;
      end else if (r_state == STREAM && next_bit) begin
        if (r_bit == 3'(SEG_W - 1)) begin
          r_bit <= '0;
          if (w_last_bit) r_done <= 1'b1;
          else            r_dig  <= r_dig + CW'(1);
        end else begin
          r_bit <= r_bit + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_stream_encoder.sv
// tb_seg_stream_encoder: randomized self-checking bench for seg_stream_encoder.
// Expected frames come from an arithmetic digit model (div/mod by radix).
module tb_seg_stream_encoder;

  localparam int DATA_W = 16;
  localparam int MAXD   = 5;
  localparam int SEG_W  = 8;
  localparam int CW     = $clog2(MAXD + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] data;
  logic [CW-1:0]     digit_count;
  logic              hex_mode;
  logic [MAXD-1:0]   dp_mask;
  logic              next_bit;
  logic              bit_data, bit_valid, busy, done, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_stream_encoder #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAXD),
    .SEG_W      (SEG_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data        (data),
    .digit_count (digit_count),
    .hex_mode    (hex_mode),
    .dp_mask     (dp_mask),
    .next_bit    (next_bit),
    .bit_data    (bit_data),
    .bit_valid   (bit_valid),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  logic [7:0] lut [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  int unsigned exp_nd;
  logic [7:0]  exp_bytes [MAXD];
  bit          exp_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int unsigned value, input int unsigned dc,
                                input bit hex, input logic [MAXD-1:0] dpm);
    int unsigned base, v, lim, msd;
    int unsigned dig [MAXD];
    exp_nd = (dc == 0) ? 1 : ((dc > MAXD) ? MAXD : dc);
    base = hex ? 16 : 10;
    v = value;
    for (int unsigned d = 0; d < MAXD; d++) begin
      dig[d] = v % base;
      v = v / base;
    end
    lim = 1;
    for (int unsigned d = 0; d < exp_nd; d++) lim = lim * base;
    exp_ovf = (value >= lim);
    msd = 0;
    for (int unsigned d = 0; d < exp_nd; d++) if (dig[d] != 0) msd = d;
    for (int unsigned d = 0; d < MAXD; d++) begin
      exp_bytes[d] = {dpm[d], lut[dig[d]][6:0]};
`ifdef LEADING_ZERO_BLANK_EN
      if (d > msd) exp_bytes[d] = {dpm[d], 7'h00};
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    start       = 1'($urandom_range(0, 1));
    data        = DATA_W'($urandom);
    hex_mode    = 1'($urandom_range(0, 1));
    digit_count = CW'($urandom);
    dp_mask     = MAXD'($urandom);
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] val, input int unsigned dc, input bit hex,
                           input logic [MAXD-1:0] dpm, input bit cont, input bit inject,
                           input string name);
    int unsigned lat;
    logic [7:0]  got;
    bit          last;
    model(val, dc, hex, dpm);
    start = 1'b1; data = val; digit_count = CW'(dc); hex_mode = hex; dp_mask = dpm;
    next_bit = 1'b0;
    step();
    start = 1'b0;
    check_eq({name, ".busy"}, busy, 1);
    if (!hex) check_eq({name, ".ovf_clr"}, overflow, 0);
    lat = 1;
    while (!bit_valid && lat < 100) begin
      if (inject) scramble_inputs();
      step();
      lat++;
    end
    start = 1'b0;
    check_eq({name, ".lat"}, lat, hex ? 1 : DATA_W + 1);
    if (!bit_valid) return;
    check_eq({name, ".ovf"}, overflow, exp_ovf);
    for (int unsigned d = 0; d < exp_nd; d++) begin
      got = '0;
      for (int unsigned b = 0; b < SEG_W; b++) begin
        if (!cont) repeat ($urandom_range(0, 2)) step();
        got[b] = bit_data;
        next_bit = 1'b1;
        last = (d == exp_nd - 1) && (b == SEG_W - 1);
        if (inject) scramble_inputs();
        if (last) start = 1'b0;
        step();
        if (!cont || last) next_bit = 1'b0;
      end
      check_eq($sformatf("%s.byte%0d", name, d), got, exp_bytes[d]);
    end
    check_eq({name, ".done"}, done, 1);
    check_eq({name, ".busy_end"}, busy, 0);
    check_eq({name, ".valid_end"}, bit_valid, 0);
    check_eq({name, ".ovf_end"}, overflow, exp_ovf);
    step();
    check_eq({name, ".done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; next_bit = 1'b0; data = '0;
    digit_count = '0; hex_mode = 1'b0; dp_mask = '0;
    repeat (3) step();
    check_eq("rst.bit_data", bit_data, 0);
    check_eq("rst.bit_valid", bit_valid, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.overflow", overflow, 0);
    rst = 1'b0;
    step();

    run_frame(16'd1234,  4, 1'b0, 5'b00000, 1'b0, 1'b0, "dec1234");
    run_frame(16'hBEEF,  4, 1'b1, 5'b00000, 1'b1, 1'b0, "hexBEEF");
    run_frame(16'd12345, 3, 1'b0, 5'b00010, 1'b0, 1'b0, "dec12345");
    run_frame(16'd7,     4, 1'b0, 5'b00000, 1'b0, 1'b0, "dec7");
    run_frame(16'd7,     0, 1'b0, 5'b00000, 1'b0, 1'b0, "cnt0");
    run_frame(16'd4321,  5, 1'b0, 5'b10101, 1'b1, 1'b1, "inject_cont");
    run_frame(16'hFFFF,  7, 1'b1, 5'b11111, 1'b0, 1'b1, "hex_clamp");

    // Abort mid-frame with reset, then a clean frame.
    start = 1'b1; data = 16'h1234; digit_count = CW'(4); hex_mode = 1'b1; dp_mask = '0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_bit = 1'b1;
      step();
      next_bit = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort.busy", busy, 0);
    check_eq("abort.bit_valid", bit_valid, 0);
    check_eq("abort.done", done, 0);
    step();
    check_eq("abort.done_later", done, 0);
    run_frame(16'd9, 1, 1'b1, 5'b00000, 1'b0, 1'b0, "after_rst");

    for (int t = 0; t < 25; t++) begin
      logic [DATA_W-1:0] v;
      case ($urandom_range(0, 2))
        0:       v = DATA_W'($urandom);
        1:       v = DATA_W'($urandom_range(0, 99));
        default: v = DATA_W'($urandom_range(0, 15));
      endcase
      run_frame(v, $urandom_range(0, 7), 1'($urandom_range(0, 1)), MAXD'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
